cache_mem_arbiter: RTL and testbench

//  Shares the single 16-bit-address / 32-bit-data backing-memory port between the

---
 rtl/cache_mem_pkg.sv | 21 ++
 rtl/cache_mem_arbiter_rr_arb2.sv | 25 ++
 rtl/cache_mem_arbiter.sv | 131 +++++++++++++
 tb/tb_cache_mem_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_mem_pkg.sv
// Shared types and defaults for the cache-to-memory arbiter and the caches around it.
`timescale 1ns/1ps
package cache_mem_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_RD_LAT = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR      = 2'd2,
        RESP    = 2'd3
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/cache_mem_arbiter_rr_arb2.sv
// Two-way round-robin pick between the icache and dcache miss paths.
// The requester that was not granted last wins a tie; a lone requester always wins.
`timescale 1ns/1ps
module rr_arb2
    import cache_mem_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  owner_t last_gnt,
    output logic   gnt_valid,
    output owner_t gnt_owner
);

    // Pick the winner from the current requests and the previous grant
    always_comb begin
        gnt_valid = i_req | d_req;
        gnt_owner = OWN_I;
        if (i_req && d_req) begin
            gnt_owner = (last_gnt == OWN_I) ? OWN_D : OWN_I;
        end else if (d_req) begin
            gnt_owner = OWN_D;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the single backing-memory port between the icache miss path (reads only)
// and the dcache miss path (line fill reads or dirty write-backs), one transaction
// at a time. Reads wait a fixed latency; the result is handed back with a one-cycle ack.
`timescale 1ns/1ps
module cache_mem_arbiter
    import cache_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rden,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_rdata
);

    // One extra bit so the counter can step past the last wait value without wrapping
    localparam int CNT_W = $clog2(RD_LAT) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RD_LAT - 1);

    state_t           state;
    owner_t           owner;
    owner_t           last_gnt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             gnt_valid;
    owner_t           gnt_owner;
    logic             grant_we;

    assign cnt_next = cnt + CNT_W'(1);
    // The icache can only read, so a write needs the dcache to own the grant
    assign grant_we = (gnt_owner == OWN_D) && d_we;

    rr_arb2 u_arb (
        .i_req     (i_req),
        .d_req     (d_req),
        .last_gnt  (last_gnt),
        .gnt_valid (gnt_valid),
        .gnt_owner (gnt_owner)
    );

    // Transaction sequencer: grant, wait/write, respond, then back to idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= OWN_I;
            last_gnt  <= OWN_I;
            cnt       <= '0;
            i_ack     <= 1'b0;
            i_rdata   <= '0;
            d_ack     <= 1'b0;
            d_rdata   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_rden  <= 1'b0;
            mem_wren  <= 1'b0;
        end else begin
            mem_rden <= 1'b0;
            mem_wren <= 1'b0;
            i_ack    <= 1'b0;
            d_ack    <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        owner     <= gnt_owner;
                        last_gnt  <= gnt_owner;
                        cnt       <= '0;
                        mem_addr  <= (gnt_owner == OWN_D) ? d_addr : i_addr;
                        mem_wdata <= (gnt_owner == OWN_D) ? d_wdata : '0;
                        if (grant_we) begin
                            mem_wren <= 1'b1;
                            state    <= WR;
                        end else begin
                            // With a one-cycle latency the strobe lands in the first wait cycle
                            mem_rden <= (RD_LAT == 1);
                            state    <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    cnt <= cnt_next;
                    if (cnt == LAST_CNT) begin
                        state <= RESP;
                        if (owner == OWN_I) begin
                            i_ack   <= 1'b1;
                            i_rdata <= mem_rdata;
                        end else begin
                            d_ack   <= 1'b1;
                            d_rdata <= mem_rdata;
                        end
                    end else begin
                        mem_rden <= (cnt_next == LAST_CNT);
                    end
                end
                WR: begin
                    state <= RESP;
                    if (owner == OWN_I) begin
                        i_ack   <= 1'b1;
                        i_rdata <= '0;
                    end else begin
                        d_ack   <= 1'b1;
                        d_rdata <= '0;
                    end
                end
                RESP: begin
                    i_rdata <= '0;
                    d_rdata <= '0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a table of single transactions plus
// hand-written sequences for arbitration, mid-transaction changes, reset abort
// and a one-cycle-latency build.
`timescale 1ns/1ps
module tb_cache_mem_arbiter;
    import cache_mem_pkg::*;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int LAT = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, d_req, d_we;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic          i_ack, d_ack, mem_rden, mem_wren;
    logic [DW-1:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    logic          i_req_s;
    logic [AW-1:0] i_addr_s;
    logic          i_ack_s, d_ack_s, mem_rden_s, mem_wren_s;
    logic [DW-1:0] i_rdata_s, d_rdata_s, mem_wdata_s, mem_rdata_s;
    logic [AW-1:0] mem_addr_s;

    int checks = 0;
    int errors = 0;
    logic overlap_seen = 1'b0;

    always #5 clk = ~clk;

    // Memory model: one known word, otherwise a pattern derived from the address
    function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
        return (a == 16'h0040) ? 32'hDEADBEEF : {16'hA5A5, a};
    endfunction

    assign mem_rdata   = mem_model(mem_addr);
    assign mem_rdata_s = mem_model(mem_addr_s);

    cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rden(mem_rden),
        .mem_wren(mem_wren), .mem_rdata(mem_rdata)
    );

    cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut_lat1 (
        .clk(clk), .rst(rst),
        .i_req(i_req_s), .i_addr(i_addr_s), .i_ack(i_ack_s), .i_rdata(i_rdata_s),
        .d_req(1'b0), .d_we(1'b0), .d_addr('0), .d_wdata('0),
        .d_ack(d_ack_s), .d_rdata(d_rdata_s),
        .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s), .mem_rden(mem_rden_s),
        .mem_wren(mem_wren_s), .mem_rdata(mem_rdata_s)
    );

    always @(negedge clk) begin
        if ((mem_rden && mem_wren) || (mem_rden_s && mem_wren_s)) overlap_seen = 1'b1;
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Launch one transaction and record what the DUT does, cycle by cycle after the grant edge
    task automatic apply_stimulus(
        input  logic          is_d,
        input  logic          we,
        input  logic [AW-1:0] addr,
        input  logic [DW-1:0] wdata,
        input  int            change_at,
        output int            rden_cyc,
        output int            wren_cyc,
        output int            ack_cyc,
        output int            rden_n,
        output int            wren_n,
        output logic          other_ack,
        output logic [DW-1:0] ack_data,
        output logic [AW-1:0] strobe_addr,
        output logic [DW-1:0] strobe_wdata,
        output logic          cleared
    );
        rden_cyc = 0; wren_cyc = 0; ack_cyc = 0; rden_n = 0; wren_n = 0;
        other_ack = 1'b0; ack_data = '0; strobe_addr = '0; strobe_wdata = '0; cleared = 1'b0;
        @(negedge clk);
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (mem_rden) begin rden_n++; rden_cyc = k; strobe_addr = mem_addr; end
            if (mem_wren) begin
                wren_n++; wren_cyc = k; strobe_addr = mem_addr; strobe_wdata = mem_wdata;
            end
            if (is_d ? i_ack : d_ack) other_ack = 1'b1;
            if (k == change_at) begin
                d_addr = 16'hFFFF; i_addr = 16'hFFFF; d_wdata = 32'h0;
            end
            if (is_d ? d_ack : i_ack) begin
                ack_cyc  = k;
                ack_data = is_d ? d_rdata : i_rdata;
                i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
                @(negedge clk);
                cleared = (i_rdata == '0) && (d_rdata == '0) && !i_ack && !d_ack;
                break;
            end
        end
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    endtask

    typedef struct {
        logic          is_d;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            rden_cyc;
        int            wren_cyc;
        int            ack_cyc;
        logic [DW-1:0] rdata;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int rc, wc, ac, rn, wn;
        logic oa, cl;
        logic [DW-1:0] ad, sw;
        logic [AW-1:0] sa;
        int owners[4];
        logic [DW-1:0] datas[4];
        int n_acks;
        logic both_ack;

        vecs[0] = '{1'b0, 1'b0, 16'h0040, 32'h0,        LAT, 0, LAT + 1, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 1'b1, 16'h1234, 32'hCAFEF00D, 0,   1, 2,       32'h0};
        vecs[2] = '{1'b1, 1'b0, 16'h0100, 32'h0,        LAT, 0, LAT + 1, 32'hA5A50100};
        vecs[3] = '{1'b0, 1'b0, 16'hFFFF, 32'h0,        LAT, 0, LAT + 1, 32'hA5A5FFFF};
        vecs[4] = '{1'b1, 1'b1, 16'h0000, 32'h00000001, 0,   1, 2,       32'h0};

        i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
        i_req_s = 0; i_addr_s = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_output("reset_acks", {30'b0, i_ack, d_ack}, 32'h0);
        check_output("reset_strobes", {30'b0, mem_rden, mem_wren}, 32'h0);
        check_output("reset_i_rdata", i_rdata, 32'h0);
        check_output("reset_d_rdata", d_rdata, 32'h0);
        check_output("reset_mem_addr", {16'b0, mem_addr}, 32'h0);
        check_output("reset_mem_wdata", mem_wdata, 32'h0);
        rst = 1'b0;

        // Single transactions from the table
        for (int v = 0; v < 5; v++) begin
            apply_stimulus(vecs[v].is_d, vecs[v].we, vecs[v].addr, vecs[v].wdata, 0,
                           rc, wc, ac, rn, wn, oa, ad, sa, sw, cl);
            check_output($sformatf("v%0d_rden_cyc", v), rc, vecs[v].rden_cyc);
            check_output($sformatf("v%0d_wren_cyc", v), wc, vecs[v].wren_cyc);
            check_output($sformatf("v%0d_ack_cyc", v), ac, vecs[v].ack_cyc);
            check_output($sformatf("v%0d_rdata", v), ad, vecs[v].rdata);
            check_output($sformatf("v%0d_rden_count", v), rn, vecs[v].we ? 0 : 1);
            check_output($sformatf("v%0d_wren_count", v), wn, vecs[v].we ? 1 : 0);
            check_output($sformatf("v%0d_other_ack", v), {31'b0, oa}, 32'h0);
            check_output($sformatf("v%0d_mem_addr", v), {16'b0, sa}, {16'b0, vecs[v].addr});
            check_output($sformatf("v%0d_rdata_cleared", v), {31'b0, cl}, 32'h1);
            if (vecs[v].we)
                check_output($sformatf("v%0d_mem_wdata", v), sw, vecs[v].wdata);
        end

        // Address change mid-read is ignored
        apply_stimulus(1'b1, 1'b0, 16'h0200, 32'h0, 3, rc, wc, ac, rn, wn, oa, ad, sa, sw, cl);
        check_output("midchg_mem_addr", {16'b0, sa}, 32'h00000200);
        check_output("midchg_ack_cyc", ac, LAT + 1);
        check_output("midchg_rdata", ad, 32'hA5A50200);

        // Simultaneous requests after reset: dcache first, then alternate
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        i_req = 1'b1; i_addr = 16'h0040;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0300;
        n_acks = 0; both_ack = 1'b0;
        for (int k = 0; k < 200 && n_acks < 4; k++) begin
            @(negedge clk);
            if (i_ack && d_ack) both_ack = 1'b1;
            if (d_ack) begin owners[n_acks] = 1; datas[n_acks] = d_rdata; n_acks++; end
            else if (i_ack) begin owners[n_acks] = 0; datas[n_acks] = i_rdata; n_acks++; end
        end
        i_req = 1'b0; d_req = 1'b0;
        check_output("rr_ack_count", n_acks, 4);
        check_output("rr_both_ack", {31'b0, both_ack}, 32'h0);
        if (n_acks == 4) begin
            for (int j = 0; j < 4; j++) begin
                check_output($sformatf("rr_owner%0d", j), owners[j], (j % 2 == 0) ? 1 : 0);
                check_output($sformatf("rr_data%0d", j), datas[j],
                             (j % 2 == 0) ? 32'hA5A50300 : 32'hDEADBEEF);
            end
        end
        repeat (2) @(negedge clk);

        // Reset during the fifth wait cycle aborts the read; held request is re-granted
        i_req = 1'b1; i_addr = 16'h0040;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check_output("abort_outputs_now",
                     {31'b0, (i_ack | d_ack | mem_rden | mem_wren | (|i_rdata) | (|d_rdata)
                              | (|mem_addr) | (|mem_wdata))}, 32'h0);
        @(negedge clk);
        check_output("abort_outputs_next",
                     {31'b0, (i_ack | d_ack | mem_rden | mem_wren | (|mem_addr))}, 32'h0);
        rst = 1'b0;
        ac = 0; rc = 0; ad = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (mem_rden) rc = k;
            if (i_ack) begin ac = k; ad = i_rdata; i_req = 1'b0; break; end
        end
        i_req = 1'b0;
        check_output("abort_regrant_rden", rc, LAT);
        check_output("abort_regrant_ack", ac, LAT + 1);
        check_output("abort_regrant_data", ad, 32'hDEADBEEF);

        // One-cycle latency build
        @(negedge clk);
        i_req_s = 1'b1; i_addr_s = 16'h0040;
        ac = 0; rc = 0; rn = 0; ad = '0; oa = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (mem_rden_s) begin rc = k; rn++; end
            if (d_ack_s) oa = 1'b1;
            if (i_ack_s) begin ac = k; ad = i_rdata_s; i_req_s = 1'b0; break; end
        end
        i_req_s = 1'b0;
        check_output("lat1_rden_cyc", rc, 1);
        check_output("lat1_rden_count", rn, 1);
        check_output("lat1_ack_cyc", ac, 2);
        check_output("lat1_data", ad, 32'hDEADBEEF);
        check_output("lat1_d_ack", {31'b0, oa}, 32'h0);

        repeat (2) @(negedge clk);
        check_output("strobe_overlap", {31'b0, overlap_seen}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
